uart_tx_controller: RTL and testbench

UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

---
 rtl/uart_tx_controller_if.sv | 32 +++
 rtl/uart_tx_controller.sv | 132 +++++++++++++
 tb/tb_uart_tx_controller.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_controller_if.sv
// Control bundle between the UART transmit controller and its datapath/baud logic.
// Latency: none; this file only declares wires.
// Backpressure: none; Data_valid is a request that the controller drops while busy.
//
// Ports:
//   BIT_TICK   - one-clk pulse per bit period from the baud generator
//   Data_valid - request to send the word on the datapath input
//   PAR_EN     - parity enable, captured when the request is accepted
//   busy, ser_load, ser_shift, mux_sel, bit_count, done - controller outputs
interface uart_tx_controller_if;
  logic       BIT_TICK;
  logic       Data_valid;
  logic       PAR_EN;
  logic       busy;
  logic       ser_load;
  logic       ser_shift;
  logic [1:0] mux_sel;
  logic [3:0] bit_count;
  logic       done;

  // master: the datapath/baud side that issues requests and watches the controller
  modport master (
    output BIT_TICK, Data_valid, PAR_EN,
    input  busy, ser_load, ser_shift, mux_sel, bit_count, done
  );

  // slave: the controller itself
  modport slave (
    input  BIT_TICK, Data_valid, PAR_EN,
    output busy, ser_load, ser_shift, mux_sel, bit_count, done
  );
endinterface

// File: rtl/uart_tx_controller.sv
// UART transmit controller: sequences start, data, optional parity and stop bits.
// Latency: ser_load one cycle after the request; the start bit begins on the next BIT_TICK.
// Backpressure: busy high from LOAD until IDLE; requests are ignored while busy, except in STOP.
//
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - uart_tx_controller_if.slave (tick/request/parity-enable in, strobes/select/status out)
module uart_tx_controller #(
  parameter int DATA_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_tx_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_DATA   = 2'b01;
  localparam logic [1:0] MUX_PARITY = 2'b10;
  localparam logic [1:0] MUX_IDLE   = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] bit_count_q, bit_count_d;
  logic       par_en_q, par_en_d;
  logic       done_q, done_d;

  logic       busy_c;
  logic       ser_load_c;
  logic       ser_shift_c;
  logic [1:0] mux_sel_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_count_q <= 4'd0;
      par_en_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      par_en_q    <= par_en_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic. BIT_TICK is level-sensitive: a tick held high advances
  // the FSM once per cycle it is asserted.
  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    par_en_d    = par_en_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Data_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Parity enable is frozen here so later PAR_EN changes cannot reshape the frame.
        // A tick in this cycle is deliberately dropped.
        par_en_d = bus.PAR_EN;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (bus.BIT_TICK) state_d = S_START;
      end
      S_START: begin
        if (bus.BIT_TICK) begin
          state_d     = S_DATA;
          bit_count_d = 4'd0;
        end
      end
      S_DATA: begin
        if (bus.BIT_TICK) begin
          if (bit_count_q < LAST_BIT) begin
            bit_count_d = bit_count_q + 4'd1;
          end else begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bus.BIT_TICK) state_d = S_STOP;
      end
      S_STOP: begin
        if (bus.BIT_TICK) begin
          done_d  = 1'b1;
          // A request present at the stop-bit boundary starts the next frame immediately.
          state_d = bus.Data_valid ? S_LOAD : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy_c      = (state_q != S_IDLE);
    ser_load_c  = (state_q == S_LOAD);
    // The serializer already presents bit 0 after the load, so only the ticks that
    // move on to another data bit shift; the tick that ends the last bit does not.
    ser_shift_c = (state_q == S_DATA) && bus.BIT_TICK && (bit_count_q < LAST_BIT);
    case (state_q)
      S_START:  mux_sel_c = MUX_START;
      S_DATA:   mux_sel_c = MUX_DATA;
      S_PARITY: mux_sel_c = MUX_PARITY;
      default:  mux_sel_c = MUX_IDLE;
    endcase
  end

  assign bus.busy      = busy_c;
  assign bus.ser_load  = ser_load_c;
  assign bus.ser_shift = ser_shift_c;
  assign bus.mux_sel   = mux_sel_c;
  assign bus.bit_count = bit_count_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Self-checking bench for uart_tx_controller: directed requests, scoreboarded frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_controller;
  localparam int DW = 8;
  localparam int TP = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_controller_if bus();

  uart_tx_controller #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Baud tick: periodic every TP cycles when enabled, plus a manual override.
  logic tick_en;
  logic tick_man;
  logic per_tick;
  int   tick_cnt;
  assign bus.BIT_TICK = tick_man | (tick_en & per_tick);

  initial begin
    per_tick = 1'b0;
    tick_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!tick_en) begin
        tick_cnt = 0;
        per_tick = 1'b0;
      end else begin
        tick_cnt = (tick_cnt == TP - 1) ? 0 : tick_cnt + 1;
        per_tick = (tick_cnt == TP - 1);
      end
    end
  end

  typedef struct packed {
    logic       par;
    logic       busy_after;
    logic [7:0] pre;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   n_done = 0;

  function automatic exp_t mk(logic par, logic busy_after, int pre);
    exp_t e;
    e.par        = par;
    e.busy_after = busy_after;
    e.pre        = 8'(pre);
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor accumulators for the frame in progress
  int          a_load, a_shift, a_ticks, a_pre, a_par, a_chg, a_maxbc;
  logic [15:0] a_hist;
  logic [1:0]  last_mux;
  logic        inframe;

  task clr_acc();
    a_load   = 0;
    a_shift  = 0;
    a_ticks  = 0;
    a_pre    = 0;
    a_par    = 0;
    a_chg    = 0;
    a_maxbc  = 0;
    a_hist   = 16'd0;
    last_mux = 2'b11;
    inframe  = 1'b0;
  endtask

  initial begin
    exp_t e;
    clr_acc();
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        clr_acc();
        continue;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_ticks",   a_ticks, DW + 2 + (e.par ? 1 : 0));
          chk("mux_sequence",  int'(a_hist), e.par ? 32'h1B : 32'h07);
          chk("mux_changes",   a_chg, e.par ? 4 : 3);
          chk("shift_pulses",  a_shift, DW - 1);
          chk("load_pulses",   a_load, 1);
          chk("parity_cycles", a_par, e.par ? TP : 0);
          chk("max_bitcount",  a_maxbc, DW - 1);
          chk("pre_start_ticks", a_pre, int'(e.pre));
          chk("busy_at_done",  int'(bus.busy), int'(e.busy_after));
        end
        clr_acc();
      end
      if (bus.ser_load === 1'b1) a_load++;
      if (bus.ser_shift === 1'b1) a_shift++;
      if (bus.mux_sel === 2'b00) inframe = 1'b1;
      if (inframe) begin
        if (bus.BIT_TICK === 1'b1) a_ticks++;
        if (bus.mux_sel !== last_mux) begin
          a_hist   = {a_hist[13:0], bus.mux_sel};
          a_chg++;
          last_mux = bus.mux_sel;
        end
        if (bus.mux_sel === 2'b10) a_par++;
        if (int'(bus.bit_count) > a_maxbc) a_maxbc = int'(bus.bit_count);
      end else if (bus.busy === 1'b1 && bus.BIT_TICK === 1'b1) begin
        a_pre++;
      end
    end
  end

  // Stimulus helpers; they return at posedge+2.
  task automatic sync_tick();
    int b = 0;
    @(posedge clk); #2;
    while (bus.BIT_TICK !== 1'b1 && b < 100) begin
      @(posedge clk); #2;
      b++;
    end
    if (b >= 100) chk("tick_timeout", 0, 1);
  endtask

  task automatic request(logic par);
    sync_tick();
    bus.PAR_EN     = par;
    bus.Data_valid = 1'b1;
    @(posedge clk); #2;
    bus.Data_valid = 1'b0;
  endtask

  task automatic wait_mux(logic [1:0] val);
    int b = 0;
    while (bus.mux_sel !== val && b < 1000) begin
      @(posedge clk); #2;
      b++;
    end
    if (b >= 1000) chk("mux_wait_timeout", 0, 1);
  endtask

  task automatic wait_done(int target);
    int b = 0;
    while (n_done < target && b < 3000) begin
      @(posedge clk);
      b++;
    end
    #2;
    chk("frames_done", n_done, target);
  endtask

  initial begin
    int exp_n;
    int nl;
    int b;
    exp_n          = 0;
    rst_n          = 1'b0;
    bus.Data_valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    tick_man       = 1'b0;
    tick_en        = 1'b1;
    #1;
    chk("rst_busy",      int'(bus.busy), 0);
    chk("rst_mux_sel",   int'(bus.mux_sel), 3);
    chk("rst_ser_load",  int'(bus.ser_load), 0);
    chk("rst_done",      int'(bus.done), 0);
    chk("rst_bit_count", int'(bus.bit_count), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Plain frame without parity
    exp_q.push_back(mk(1'b0, 1'b0, 1));
    request(1'b0);
    exp_n++;
    wait_done(exp_n);
    repeat (3) @(posedge clk);
    #2 chk("idle_after_frame_busy", int'(bus.busy), 0);

    // Parity frame; PAR_EN dropped mid-frame must not remove the parity bit
    exp_q.push_back(mk(1'b1, 1'b0, 1));
    request(1'b1);
    wait_mux(2'b01);
    bus.PAR_EN = 1'b0;
    exp_n++;
    wait_done(exp_n);

    // Data_valid held high: three back-to-back frames
    exp_q.push_back(mk(1'b0, 1'b1, 1));
    exp_q.push_back(mk(1'b0, 1'b1, 1));
    exp_q.push_back(mk(1'b0, 1'b0, 1));
    sync_tick();
    bus.PAR_EN     = 1'b0;
    bus.Data_valid = 1'b1;
    nl = 0;
    b  = 0;
    while (nl < 3 && b < 3000) begin
      @(posedge clk); #2;
      if (bus.ser_load === 1'b1) nl++;
      b++;
    end
    bus.Data_valid = 1'b0;
    chk("b2b_loads_seen", nl, 3);
    exp_n += 3;
    wait_done(exp_n);

    // Request pulsed during DATA is ignored
    exp_q.push_back(mk(1'b0, 1'b0, 1));
    request(1'b0);
    wait_mux(2'b01);
    bus.Data_valid = 1'b1;
    @(posedge clk); #2;
    bus.Data_valid = 1'b0;
    exp_n++;
    wait_done(exp_n);
    repeat (40) @(posedge clk);
    #2;
    chk("ignored_req_busy",  int'(bus.busy), 0);
    chk("ignored_req_count", n_done, exp_n);

    // Asynchronous reset at bit_count=4 aborts the frame without done
    request(1'b0);
    b = 0;
    while (!(bus.bit_count === 4'd4 && bus.mux_sel === 2'b01) && b < 1000) begin
      @(posedge clk); #2;
      b++;
    end
    chk("reach_bit4", int'(bus.bit_count), 4);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_mux_sel",   int'(bus.mux_sel), 3);
    chk("midrst_busy",      int'(bus.busy), 0);
    chk("midrst_bit_count", int'(bus.bit_count), 0);
    chk("midrst_done",      int'(bus.done), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #2 chk("no_done_after_reset", n_done, exp_n);
    exp_q.push_back(mk(1'b0, 1'b0, 1));
    request(1'b0);
    exp_n++;
    wait_done(exp_n);

    // Tick coincident with LOAD is dropped; START waits for the following tick
    exp_q.push_back(mk(1'b0, 1'b0, 2));
    sync_tick();
    tick_en        = 1'b0;
    @(posedge clk); #2;
    bus.PAR_EN     = 1'b0;
    bus.Data_valid = 1'b1;
    @(posedge clk); #2;
    bus.Data_valid = 1'b0;
    tick_man       = 1'b1;
    chk("load_cycle_ser_load", int'(bus.ser_load), 1);
    @(posedge clk); #2;
    tick_man = 1'b0;
    chk("after_load_tick_mux", int'(bus.mux_sel), 3);
    tick_en  = 1'b1;
    exp_n++;
    wait_done(exp_n);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
